// File: rtl/dpram_stream_pkg.sv
// dpram_stream_pkg: shared types and constants for the dual-port RAM stream reader.
package dpram_stream_pkg;
  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/dpram_stream_reader_skid.sv
// skid_fifo2: two-entry FIFO that absorbs the RAM read latency under backpressure.
module skid_fifo2
  import dpram_stream_pkg::*;
#(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       level
);
  logic [width-1:0] e0, e1;
  logic [1:0] cnt;
  logic do_pop, do_push;
  assign do_pop = pop && cnt != 2'd0;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == 2'(SKID_DEPTH);
  assign empty = cnt == 2'd0;
  assign level = cnt;
  assign dout = e0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0 <= '0;
      e1 <= '0;
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
      if (do_push && (cnt == 2'd0 || (cnt == 2'd1 && do_pop))) e0 <= din;
      else if (do_pop && cnt == 2'd2) e0 <= e1;
      if (do_push && ((cnt == 2'd1 && !do_pop) || (cnt == 2'd2 && do_pop))) e1 <= din;
    end
  end
endmodule

// File: rtl/dpram_stream_reader.sv
// dpram_stream_reader: streams a wrapping run of RAM words out as valid/ready beats.
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int words = 8,
  parameter int width = 1,
  localparam int addr_bits = $clog2(words)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [addr_bits-1:0] base_addr,
  input  logic [addr_bits:0]   count,
  output logic                 busy,
  output logic                 done,
  output logic [addr_bits-1:0] ram_addr,
  output logic                 ram_wr_en,
  output logic [width-1:0]     ram_wdata,
  input  logic [width-1:0]     ram_q,
  output logic                 out_valid,
  output logic [width-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready
);
  localparam logic [addr_bits:0] one = 1;
  localparam logic [addr_bits-1:0] top_addr = addr_bits'(words - 1);
  rd_state_t state;
  logic [addr_bits-1:0] ptr, addr_q, cur_ptr;
  logic [addr_bits:0] rem, cur_rem;
  logic inflight, inflight_last, issue, pop, room, idle, empty, full;
  logic [width:0] head;
  logic [1:0] level;
  // The first read goes out in the start cycle so data appears two cycles later.
  assign idle = state == RD_IDLE;
  assign cur_ptr = idle ? base_addr : ptr;
  assign cur_rem = idle ? count : rem;
  assign pop = out_valid && out_ready;
  assign room = int'(level) + int'(inflight) < SKID_DEPTH + int'(pop);
  assign issue = room && (idle ? start && count != '0 : state == RD_READ);
  assign ram_addr = issue ? cur_ptr : addr_q;
  assign ram_wr_en = 1'b0;
  assign ram_wdata = '0;
  assign out_valid = !empty;
  assign out_data = head[width-1:0];
  assign out_last = head[width] && !empty;
  skid_fifo2 #(.width(width + 1)) u_skid (
    .clk(clk),
    .reset_n(reset_n),
    .push(inflight),
    .din({inflight_last, ram_q}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RD_IDLE;
      ptr <= '0;
      rem <= '0;
      addr_q <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      addr_q <= ram_addr;
      inflight <= issue;
      inflight_last <= issue && cur_rem == one;
      done <= (idle && start && count == '0) || (state == RD_DRAIN && pop && out_last);
      if (issue) begin
        ptr <= cur_ptr == top_addr ? '0 : cur_ptr + 1'b1;
        rem <= cur_rem - one;
        state <= cur_rem == one ? RD_DRAIN : RD_READ;
        busy <= 1'b1;
      end
      if (state == RD_DRAIN && pop && out_last) begin
        state <= RD_IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dpram_stream_reader.sv
// tb_dpram_stream_reader: vector table of runs plus reset and count==0 corner sequences.
module tb_dpram_stream_reader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] base_addr = '0;
  logic [3:0] count = '0;
  logic busy, done, ram_wr_en, out_valid, out_last;
  logic out_ready = 1'b0;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata, out_data;
  logic [7:0] ram_q = '0;
  logic [7:0] mem [8];
  logic [8:0] sb [$];
  int total = 0;
  int bad = 0;

  typedef struct {
    int base;
    int cnt;
    int pat;
    int exp_first;
    int exp_end;
    int restart;
  } vec_t;
  vec_t vecs [8];

  dpram_stream_reader #(.words(8), .width(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_wr_en(ram_wr_en),
    .ram_wdata(ram_wdata),
    .ram_q(ram_q),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_case(input vec_t v);
    logic [8:0] e, pd;
    logic [2:0] a0;
    int first, endk, j;
    bit seen_done, stall, r;
    sb.delete();
    for (int i = 0; i < v.cnt; i++) sb.push_back({i == v.cnt - 1, mem[(v.base + i) % 8]});
    @(negedge clk);
    a0 = ram_addr;
    base_addr = 3'(v.base);
    count = 4'(v.cnt);
    start = 1'b1;
    out_ready = 1'b1;
    #1;
    if (v.cnt > 0) chk("issue_addr", 32'(ram_addr), 32'(v.base));
    else chk("idle_addr", 32'(ram_addr), 32'(a0));
    first = -1;
    endk = -1;
    stall = 1'b0;
    seen_done = 1'b0;
    pd = '0;
    j = 0;
    for (int k = 1; k <= 300 && !seen_done; k++) begin
      @(negedge clk);
      start = v.restart != 0 && k == 3;
      if (start) begin
        base_addr = 3'(v.base + 3);
        count = 4'd2;
      end
      if (v.cnt == 0) begin
        chk("zero_valid", 32'(out_valid), 0);
        chk("zero_addr", 32'(ram_addr), 32'(a0));
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_sb_empty", 32'(sb.size()), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_cycle", 32'(k), v.cnt > 0 ? 32'(endk + 1) : 32'd1);
      end else if (v.cnt > 0) chk("run_busy", 32'(busy), 1);
      if (stall) chk("stall_hold", 32'({out_valid, out_data}), 32'(pd));
      if (out_valid && first < 0) first = k;
      r = v.pat == 0 ? 1'b1 : v.pat == 1 ? (j % 3 == 0) : 1'($urandom_range(0, 1));
      j++;
      out_ready = r;
      if (out_valid && r) begin
        if (sb.size() == 0) chk("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("beat_data", 32'(out_data), 32'(e[7:0]));
          chk("beat_last", 32'(out_last), 32'(e[8]));
        end
        endk = k;
      end
      stall = out_valid && !r;
      pd = {out_valid, out_data};
    end
    start = 1'b0;
    if (!seen_done) chk("done_timeout", 0, 1);
    if (v.exp_first >= 0) chk("first_valid", 32'(first), 32'(v.exp_first));
    if (v.exp_end >= 0) chk("last_accept", 32'(endk), 32'(v.exp_end));
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 0);
    chk("idle_valid", 32'(out_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA5 ^ (i * 17));
    vecs[0] = '{2, 3, 0, 2, 4, 0};
    vecs[1] = '{6, 4, 0, 2, 5, 0};
    vecs[2] = '{3, 0, 0, -1, -1, 0};
    vecs[3] = '{5, 8, 1, 2, -1, 0};
    vecs[4] = '{1, 5, 0, 2, 6, 1};
    vecs[5] = '{7, 8, 2, 2, -1, 0};
    vecs[6] = '{0, 8, 0, 2, 9, 0};
    vecs[7] = '{4, 1, 0, 2, 2, 0};
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("wr_en", 32'(ram_wr_en), 0);
    chk("wdata", 32'(ram_wdata), 0);
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) run_case(vecs[n]);
    // Abort a run mid-flight with an asynchronous reset between clock edges.
    @(negedge clk);
    base_addr = 3'd1;
    count = 4'd8;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("prefill_valid", 32'(out_valid), 1);
    chk("prefill_busy", 32'(busy), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(out_data), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_addr", 32'(ram_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    run_case('{0, 2, 0, 2, 3, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
